// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO slice: default data width and the
// occupancy-counter width helper.
package stream_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // A counter that must hold 0..depth inclusive needs one more state than depth.
    function automatic int unsigned clog2_count(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: clocked write port without reset,
// asynchronous read port.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with registered occupancy count, almost-full flag
// and synchronous flush; storage lives in stream_fifo_mem.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int          DEPTH        = 16,
    parameter int          AFULL_THRESH = DEPTH - 4,
    localparam int unsigned CW          = clog2_count(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CW-1:0]         count,
    output logic                  almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("stream_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push, pop, mem_we;

    // Handshake outputs depend only on registered count, never on s_valid/m_ready.
    assign s_ready     = (count_q != CW'(DEPTH));
    assign m_valid     = (count_q != '0);
    assign almost_full = (count_q >= CW'(AFULL_THRESH));
    assign count       = count_q;

    assign push   = s_valid & s_ready;
    assign pop    = m_valid & m_ready;
    assign mem_we = push & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (m_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a negedge monitor keeps a reference queue
// of accepted words and compares every DUT output against it each cycle.
module tb_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [4:0]    count;
    logic          almost_full;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] popped[$];

    logic          prev_sv = 1'b0, prev_sr = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0;
    logic          prev_fl = 1'b0, prev_rst = 1'b0;
    logic [DW-1:0] prev_sd = '0, prev_md = '0;

    stream_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable at the negedge, so this is where the
    // transfer that the next posedge will perform is decided.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_count", int'(count), 0);
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_s_ready", int'(s_ready), 1);
        end else begin
            chk("count", int'(count), exp_q.size());
            chk("s_ready", int'(s_ready), int'(exp_q.size() != DEPTH));
            chk("m_valid", int'(m_valid), int'(exp_q.size() != 0));
            chk("almost_full", int'(almost_full), int'(exp_q.size() >= AFT));
            if (exp_q.size() != 0) begin
                chk("m_data", int'(m_data), int'(exp_q[0]));
            end
            if (prev_rst && prev_mv && !prev_mr && !prev_fl) begin
                chk("m_hold", int'({m_valid, m_data}), int'({1'b1, prev_md}));
            end
            if (prev_rst && prev_sv && !prev_sr && !prev_fl) begin
                assert (s_valid && s_data == prev_sd)
                else $error("FAIL producer_hold: s_valid=%0b s_data=0x%0h, required 1 / 0x%0h",
                            s_valid, s_data, prev_sd);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                logic do_pop, do_push;
                do_pop  = (exp_q.size() != 0) && m_ready;
                do_push = s_valid && (exp_q.size() != DEPTH);
                if (do_pop) begin
                    popped.push_back(m_data);
                    void'(exp_q.pop_front());
                end
                if (do_push) begin
                    exp_q.push_back(s_data);
                end
            end
        end
        prev_sv  = s_valid;  prev_sr = s_ready; prev_sd = s_data;
        prev_mv  = m_valid;  prev_mr = m_ready; prev_md = m_data;
        prev_fl  = flush;    prev_rst = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic          acc;
        int            guard;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // Reset state before any clock edge
        #2;
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_afull", int'(almost_full), 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        #1;
        chk("release_count", int'(count), 0);
        chk("release_s_ready", int'(s_ready), 1);
        step();

        // Single word
        s_valid = 1'b1; s_data = 8'hA5;
        step();
        s_valid = 1'b0;
        chk("single_m_valid", int'(m_valid), 1);
        chk("single_m_data", int'(m_data), 'hA5);
        chk("single_count", int'(count), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("single_pop_m_valid", int'(m_valid), 0);
        chk("single_pop_count", int'(count), 0);

        // Fill to full
        popped.delete();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            step();
            chk("fill_count", int'(count), i + 1);
            chk("fill_afull", int'(almost_full), int'(i + 1 >= 12));
            chk("fill_s_ready", int'(s_ready), int'(i + 1 != 16));
        end
        s_data = 8'hFF;
        repeat (3) begin
            step();
            chk("full_hold_count", int'(count), 16);
        end

        // Pop from full: no push that cycle, then push+pop together
        m_ready = 1'b1;
        step();
        chk("full_pop_count", int'(count), 15);
        chk("full_pop_s_ready", int'(s_ready), 1);
        step();
        s_valid = 1'b0;
        chk("pushpop_count", int'(count), 15);
        guard = 0;
        while (m_valid && guard < 20) begin
            step();
            guard++;
        end
        m_ready = 1'b0;
        chk("drain_done", int'(count), 0);
        chk("drain_len", popped.size(), 17);
        for (int i = 0; i < 17 && i < popped.size(); i++) begin
            chk("drain_order", int'(popped[i]), (i < 16) ? i : 'hFF);
        end

        // Wrap-around with random handshakes and an incrementing pattern
        popped.delete();
        d = '0;
        s_valid = 1'b0; s_data = d;
        for (int c = 0; c < 40; c++) begin
            if (!s_valid) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = d;
            end
            m_ready = 1'($urandom_range(0, 1));
            acc = s_valid && s_ready;
            step();
            if (acc) begin
                d = d + 8'd1;
                s_valid = 1'b0;
            end
        end
        m_ready = 1'b1;
        guard = 0;
        while ((s_valid || m_valid) && guard < 60) begin
            acc = s_valid && s_ready;
            step();
            if (acc) s_valid = 1'b0;
            guard++;
        end
        m_ready = 1'b0;
        chk("wrap_drained", int'(count), 0);
        chk("wrap_len", popped.size(), int'(d));
        for (int i = 0; i < popped.size(); i++) begin
            chk("wrap_order", int'(popped[i]), i & 'hFF);
        end

        // Flush with coincident push and pop
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = 8'h40 + DW'(i);
            step();
        end
        s_valid = 1'b0;
        chk("pre_flush_count", int'(count), 7);
        popped.delete();
        flush = 1'b1; s_valid = 1'b1; s_data = 8'h99; m_ready = 1'b1;
        step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_m_valid", int'(m_valid), 0);
        chk("flush_s_ready", int'(s_ready), 1);
        s_valid = 1'b1; s_data = 8'h3C;
        step();
        s_valid = 1'b0;
        chk("post_flush_m_valid", int'(m_valid), 1);
        chk("post_flush_m_data", int'(m_data), 'h3C);
        chk("post_flush_count", int'(count), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("post_flush_popped", popped.size(), 1);
        if (popped.size() != 0) chk("post_flush_word", int'(popped[0]), 'h3C);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'h70 + DW'(i);
            step();
        end
        s_valid = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_m_valid", int'(m_valid), 0);
        chk("async_rst_s_ready", int'(s_ready), 1);
        chk("async_rst_afull", int'(almost_full), 0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("after_rst_count", int'(count), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous valid/ready stream FIFO. This is the DUT-side stage driven by the driver component and observed by the monitor components on both ports.
- Buffers DEPTH words between an upstream producer (s_*) and a downstream consumer (m_*).
- Reports an occupancy count and an almost-full flag, and supports a synchronous flush.
- Fall-through with registered flags: a word written into an empty FIFO is presented one cycle later.

Parameters:
- DATA_WIDTH, 8, width of s_data and m_data.
- DEPTH, 16, number of storage entries. Must be a power of two, ≥ 2. Elaboration error otherwise.
- AFULL_THRESH, DEPTH-4, almost_full asserts when count ≥ AFULL_THRESH. Legal range is 1..DEPTH.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  producer has a word.
- s_ready  out  1  FIFO can accept; equals (count != DEPTH).
- s_data  in  DATA_WIDTH  write word.
- m_valid  out  1  head word available; equals (count != 0).
- m_ready  in  1  consumer accepts the head.
- m_data  out  DATA_WIDTH  head word; valid only while m_valid=1.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AFULL_THRESH.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - wr_ptr=0, rd_ptr=0, count=0.
  - s_ready=1, m_valid=0, almost_full=0.
  - Storage contents are not reset; m_data is don't-care while m_valid=0.
- Transfer rules:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - Both are evaluated on the same edge.
- s_ready and m_valid are pure functions of registered count. No combinational path from s_valid/m_ready to any output.
- m_data is read combinationally from mem[rd_ptr] (registered storage, mux output).
- Latency: a push at edge N into an empty FIFO gives m_valid=1 and m_data = that word after edge N. There is no same-cycle bypass.
- Count update per edge:
  - push only: count+1.
  - pop only: count−1.
  - both: unchanged.
  - neither: unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0. wr_ptr advances on push; rd_ptr advances on pop.
- Full (count=DEPTH):
  - s_ready=0, so no push occurs even if m_ready=1 on that cycle.
  - Pop frees one slot and s_ready=1 on the next cycle.
- Empty (count=0):
  - m_valid=0, so no pop occurs.
  - s_valid with s_ready=1 pushes normally.
- almost_full is combinational from registered count. It updates in the same cycle count changes.
- flush=1 at an edge:
  - wr_ptr, rd_ptr and count go to 0.
  - Any coincident push or pop is discarded.
  - Flush takes priority over all other events.
- Reset mid-operation: contents are lost and all outputs go immediately to reset values. The upstream protocol (s_valid hold) is the producer's responsibility.
- Protocol assumptions, checked by bench assertions:
  - A producer holds s_valid and s_data stable until accepted.
  - m_valid/m_data stay stable until popped, unless flush or reset occurs.
- Ordering is strict FIFO. No word is lost or duplicated.

Decomposition:
- A shared package stream_pkg holds only the function clog2_count(depth) and a localparam default DATA_WIDTH. No typedefs are needed beyond the logic vectors.
- One sub-module, stream_fifo_mem:
  - DEPTH×DATA_WIDTH register array.
  - Write port: we, waddr, wdata; clocked, no reset.
  - Asynchronous read port: raddr, rdata.
- Pointer, count and flag logic stays in stream_fifo.

Test Plan:
- Reset then idle → s_ready=1, m_valid=0, count=0, almost_full=0. Release rst_n mid-cycle and confirm outputs only change on the asynchronous assert.
- Single word: push 0xA5 at edge N with m_ready=0 → after N: m_valid=1, m_data=0xA5, count=1. Raise m_ready → after the next edge, m_valid=0, count=0.
- Fill: push 16 words 0x00..0x0F with m_ready=0.
  - almost_full rises when count=12.
  - s_ready=0 at count=16.
  - A 17th offered word (0xFF) held for 3 cycles is not accepted; count stays 16.
- Full with simultaneous push/pop: at count=16 assert m_ready=1 with s_valid=1 for 1 cycle → pop 0x00, no push, count=15. Next cycle push+pop both occur, count stays 15. Drain confirms order 0x01..0x0F then 0xFF.
- Wrap-around: 40 cycles of random s_valid/m_ready toggling with the incrementing data pattern → the scoreboard sees 0,1,2,… in order with none missing, and count never exceeds 16 or underflows.
- Flush: at count=7 assert flush together with s_valid=1 and m_ready=1 for one edge → count=0, m_valid=0, neither word transferred. The next push of 0x3C appears as m_data=0x3C one cycle later.
